// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift register mode, direction and sequencer state encodings
package shift_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - request handshake into the shift sequencer
interface shift_seq_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_dir;
  logic [CW-1:0]    req_count;

  modport master (
    output req_valid, req_data, req_dir, req_count,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_data, req_dir, req_count,
    output req_ready
  );

endinterface

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - load-then-shift command sequencer for a universal shift register
// Optional SHIFT_SEQ_ROTATE_EN feeds the outgoing bit back into the active fill input.
module shift_seq
  import shift_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0,
  localparam int  CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_if.slave       req,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_din,
  output logic             sr_lin,
  output logic             sr_rin,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_clamped;
  logic             w_accept;
  logic             w_out_bit;

  // Zero or out-of-range counts mean a full-word shift.
  assign w_cnt_clamped = ((req.req_count == '0) || (req.req_count > CW'(WIDTH)))
                         ? CW'(WIDTH) : req.req_count;
  assign w_accept  = req.req_valid && req.req_ready;
  assign w_out_bit = (r_dir == DIR_LEFT) ? sr_q[WIDTH-1] : sr_q[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_dir   <= DIR_RIGHT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_data <= req.req_data;
        r_dir  <= req.req_dir;
        r_cnt  <= w_cnt_clamped;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req.req_valid) w_next_state = LOAD;
      LOAD:    w_next_state = SHIFT;
      SHIFT:   if (r_cnt == CW'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Every output is forced quiet while reset is held, even before the state clears.
  always_comb begin
    req.req_ready = 1'b0;
    sr_mode       = MODE_HOLD;
    sr_din        = '0;
    sr_lin        = FILL;
    sr_rin        = FILL;
    ser_bit       = 1'b0;
    ser_valid     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    if (reset) begin
      busy = (r_state != IDLE);
      case (r_state)
        IDLE: req.req_ready = 1'b1;
        LOAD: begin
          sr_mode = MODE_LOAD;
          sr_din  = r_data;
        end
        SHIFT: begin
          sr_mode   = (r_dir == DIR_LEFT) ? MODE_LEFT : MODE_RIGHT;
          ser_valid = 1'b1;
          ser_bit   = w_out_bit;
`ifdef SHIFT_SEQ_ROTATE_EN
          if (r_dir == DIR_LEFT) sr_lin = w_out_bit;
          else                   sr_rin = w_out_bit;
`endif
        end
        DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode/din/lin/rin inputs. It accepts a parallel word over a valid/ready handshake, issues one load, then a programmable number of right or left shifts. It reports each outgoing serial bit, sampled from the shift register's parallel output, with a per-bit valid strobe. It raises a one-cycle done pulse when the word is finished.

Parameters:
WIDTH, 4, shift register width; must match the driven register
FILL, 1'b0, bit driven on lin/rin during shifts when rotate is compiled out
CW, $clog2(WIDTH+1), width of the shift-count field (derived; do not override)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  request valid
req_ready  output  1  sequencer can accept a request
req_data  input  WIDTH  word to load
req_dir  input  1  0 = right shift (LSB first), 1 = left shift (MSB first)
req_count  input  CW  shifts to perform; 0 or >WIDTH treated as WIDTH
sr_mode  output  2  to shift register mode: 00 hold, 01 right, 10 left, 11 load
sr_din  output  WIDTH  to shift register din
sr_lin  output  1  to shift register lin (fill for left shift)
sr_rin  output  1  to shift register rin (fill for right shift)
sr_q  input  WIDTH  shift register dout, fed back
ser_bit  output  1  outgoing serial bit
ser_valid  output  1  ser_bit valid this cycle
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset: reset low at a clk edge forces state IDLE and clears the counter and captured data/dir. While reset is low: req_ready=0, sr_mode=00, sr_din=0, ser_valid=0, done=0, busy=0. The shift register shares this reset and clears to 0.
- States: IDLE, LOAD, SHIFT, DONE. All outputs decode combinationally from registered state, data and counter.
- IDLE: req_ready=1, sr_mode=00. When req_valid && req_ready at edge T:
  - capture req_data, req_dir, and the clamped count;
  - move to LOAD.
- LOAD (cycle T+1): sr_mode=11, sr_din=captured data, req_ready=0. Next state is SHIFT. The register holds the data after edge T+1.
- SHIFT (cycles T+2 onward):
  - sr_mode=01 if dir=0, 10 if dir=1.
  - ser_valid=1; ser_bit=sr_q[0] (right) or sr_q[WIDTH-1] (left), i.e. the bit being shifted out this cycle.
  - Counter decrements each cycle. After the cycle in which the counter reaches 1, go to DONE. Exactly count cycles are spent in SHIFT.
- DONE: done=1, sr_mode=00, ser_valid=0, req_ready=0. Next state is IDLE.
- Latency: first serial bit appears in cycle T+2; done appears in cycle T+2+count. Minimum request spacing is count+3 cycles.
- Fill: the unused fill input is always driven FILL; without the optional feature, the active fill input is driven FILL too.
- Inputs are ignored outside IDLE; req_valid may stay high, and the next request is accepted in the IDLE cycle after DONE.
- sr_din is driven 0 in all states except LOAD.
- Reset mid-operation: abort immediately. No done pulse. Partial serial output is discarded by the consumer.

Optional Feature:
SHIFT_SEQ_ROTATE_EN.
- Defined: during SHIFT, the active fill input is driven with the outgoing bit (rin=sr_q[0] for right shifts, lin=sr_q[WIDTH-1] for left shifts), so the register rotates. After count=WIDTH shifts, sr_q equals the loaded word.
- Undefined: lin/rin are constant FILL; no feedback path exists.

Decomposition:
- Package shift_pkg holds:
  - mode encodings MODE_HOLD=2'b00, MODE_RIGHT=2'b01, MODE_LEFT=2'b10, MODE_LOAD=2'b11;
  - the state encoding IDLE/LOAD/SHIFT/DONE;
  - the DIR_RIGHT/DIR_LEFT constants.
- Single module; no sub-module needed. The counter and FSM are small enough to stay inline.

Test Plan:
All scenarios instantiate shift_seq driving the real 4-bit shift register, WIDTH=4, FILL=0.
- Right shift: data 4'b1011, dir=0, count=4 accepted at T -> ser_bit 1,1,0,1 in T+2..T+5; done in T+6; sr_q ends 4'b0000.
- Left shift: data 4'b1011, dir=1, count=4 -> ser_bit 1,0,1,1; sr_q ends 4'b0000; done one cycle after the last bit.
- Partial shift and clamping:
  - count=2, dir=0, data 4'b1011 -> bits 1,1; sr_q ends 4'b0010; done at T+4.
  - count=0 -> behaves as count=4.
- Back-to-back: req_valid held high with two words -> second accepted in the IDLE cycle after done; req_ready low throughout LOAD/SHIFT/DONE; no bit lost.
- Reset mid-SHIFT after 2 bits -> next cycle state IDLE, sr_mode=00, sr_q=0000, no done pulse; a fresh request then completes normally.
- With SHIFT_SEQ_ROTATE_EN: data 4'b1011, dir=0, count=4 -> bits 1,1,0,1 and sr_q ends 4'b1011; same check for dir=1.
